execute_md: RTL
===============

# execute_md

Parametrised execute stage for the pipelined RV64I/Zba core, extended with an iterative M-extension multiply/divide unit. It sits between the ID/EX and EX/MEM pipeline registers. It keeps the MEM/WB operand forwarding and Zba ALU of the existing execute stage, and generalises datapath width to `XLEN`. It adds a multi-cycle MUL/DIV path that stalls the pipeline through a busy signal to the hazard unit.

## Interface
- `XLEN`, 64: datapath width; 32 or 64.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `RD1_E`, `RD2_E`, `ImmExt_E`, `PC_E` in XLEN: register operands, immediate, PC.
- `ALUControl_E` in 4: ALU operation.
- `ALUSrc_E`, `Branch_E`, `Jump_E` in 1: SrcB select, branch, jump.
- `MDValid_E` in 1: instruction in EX is an M-extension op.
- `MDOp_E` in 3: M op, equal to funct3.
- `ALUResult_M`, `Result_W` in XLEN: forwarded data.
- `ForwardA_E`, `ForwardB_E` in 2: forwarding selects from the hazard unit.
- `ALUResult_E` out XLEN: ALU result, or M result in the DONE cycle.
- `WriteData_E` out XLEN: forwarded rs2 for stores.
- `PCTarget_E` out XLEN: `PC_E + ImmExt_E`, wraps modulo 2^XLEN.
- `PCSrc_E`, `Zero_E` out 1: branch/jump taken; ALU result is zero.
- `MDBusy_E` out 1: stall request; hazard unit holds IF/ID/EX stable and bubbles MEM.

## Operation
- Forward mux, per operand:
  - 00 selects RD.
  - 01 selects `Result_W`.
  - 10 selects `ALUResult_M`.
  - 11 is reserved and behaves as 00.
- SrcA = forwarded A. SrcB = `ALUSrc_E` ? `ImmExt_E` : forwarded B. `WriteData_E` = forwarded B.
- ALU encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 1000 XOR.
  - 0100 SH1ADD, 0110 SH2ADD, 0111 SH3ADD: B+(A<<n).
  - 0101 SLT, 1100 SLTU.
  - 1001 SLL, 1010 SRL, 1011 SRA. Shift amount is SrcB[$clog2(XLEN)-1:0].
  - 1101 ADD.UW: B + zext(A[31:0]).
  - 1110 PASS B.
  - 1111 gives 0.
- `Zero_E` = (ALU result == 0). `PCSrc_E` = (`Branch_E` & `Zero_E`) | `Jump_E`.
- M ops:
  - 000 MUL (low XLEN bits).
  - 001 MULH (s×s, high), 010 MULHSU (s×u, high), 011 MULHU (u×u, high).
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - W-variants are out of scope.
- Arithmetic: operands are converted to magnitudes, an unsigned iteration runs, and the result sign is fixed at the end. Remainder takes the dividend's sign; the quotient truncates toward zero.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE & `MDValid_E`: latch the forwarded operands and `MDOp_E`, load the counter with XLEN-1, and drive `MDBusy_E`=1 combinationally this cycle. Next state is MUL, or DIV for ops 1xx.
  - Divisor zero or signed overflow in IDLE: go straight to DONE.
  - MUL: radix-2 shift-add, one bit per cycle. Go to DONE when the counter reaches 0.
  - DIV: restoring, one quotient bit per cycle. Go to DONE when the counter reaches 0.
  - DONE: `MDBusy_E`=0 and `ALUResult_E` = M result, taken from a register. Next state is IDLE unconditionally, so the same instruction is never restarted. `Zero_E`/`PCSrc_E` still reflect the ALU path; M ops never branch.
- Special results:
  - Divide by zero: DIV/DIVU gives all-ones; REM/REMU gives the dividend.
  - DIV of -2^(XLEN-1) by -1: quotient is -2^(XLEN-1), REM is 0.
- `MDValid_E`=0 leaves the FSM in IDLE, and all outputs are purely combinational from the ALU path.

## Timing
- ALU path: combinational, 0-cycle latency, no state.
- M op, normal: EX is occupied for XLEN+2 cycles.
  - 1 accept cycle.
  - XLEN iteration cycles.
  - 1 DONE cycle.
  - `MDBusy_E` is high for the first XLEN+1 of these.
- M op, special case: 2 cycles (accept, then DONE).
- Back-to-back M ops: the second is accepted in the cycle after DONE, with no gap beyond that.
- Forwarded operands are sampled only in the accept cycle. Later changes on `ALUResult_M`/`Result_W` during the stall are ignored.
- Reset values: state IDLE, counter 0, M result register 0, `MDBusy_E` 0.
  - During `rst`=1, `MDBusy_E` is forced to 0 regardless of `MDValid_E`.
  - `rst` mid-iteration aborts the op; the next cycle is IDLE.

## Structure
- Shared package `riscv_pkg`:
  - `alu_op_t`, `md_op_t` and `fwd_sel_t` enums with the encodings above.
  - `md_state_t`.
  - Default `XLEN`.
- Sub-module `muldiv_iter`, parametrised by XLEN. It holds the FSM, counter, operand/accumulator registers and the sign/special-case logic. It exposes `start`, `op`, `a`, `b`, `busy`, `done` and `result`.
- `execute_md` holds the forwarding muxes, ALU, branch logic and result select.

## Test plan
- XLEN=64, RD1=10, RD2=20, `ALUResult_M`=100, `Result_W`=200, ADD:
  - fwd 00/00 → 30.
  - FwdA=10 → 120.
  - FwdB=01 → 210.
  - 10/01 → 300.
- Zba ops:
  - SH1ADD(10,20) → 40.
  - SH3ADD(10,20) → 100.
  - ADD.UW(A=0xFFFFFFFF_00000005, B=1) → 6.
- Branch: SUB with 7,7, `Branch_E`=1, PC=0x100, Imm=0x20 → `Zero_E`=1, `PCSrc_E`=1, `PCTarget_E`=0x120.
- Multiply:
  - MUL(-3, 7) → `MDBusy_E` high for 65 cycles, then in cycle 66 `ALUResult_E` = -21 with busy low.
  - MULHU(all-ones, 2) → 1.
  - MULH(-1, -1) → 0.
- Divide:
  - DIV(-7, 2) → -3; REM(-7, 2) → -1.
  - DIVU(5, 0) → all-ones; REMU(5, 0) → 5, each in 2 cycles.
  - DIV(0x8000…0, -1) → 0x8000…0; REM → 0.
- Reset: `rst` pulsed at iteration cycle 20 of a MUL → next cycle IDLE with `MDBusy_E`=0. Reissuing MUL(6, 7) → 42 after 66 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings and defaults for the execute stage
package riscv_pkg;
  localparam int XLEN_DEFAULT = 64;
  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_SH1ADD = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SH2ADD = 4'b0110,
    ALU_SH3ADD = 4'b0111,
    ALU_XOR    = 4'b1000,
    ALU_SLL    = 4'b1001,
    ALU_SRL    = 4'b1010,
    ALU_SRA    = 4'b1011,
    ALU_SLTU   = 4'b1100,
    ALU_ADDUW  = 4'b1101,
    ALU_PASSB  = 4'b1110,
    ALU_ZERO   = 4'b1111
  } alu_op_t;
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;
  typedef enum logic [1:0] {
    FWD_RD  = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_t;
  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MULS,
    MD_DIVS,
    MD_DONE
  } md_state_t;
endpackage

// File: rtl/execute_md_if.sv
// execute_md_if: ID/EX operands, forwarding and EX results bundled for the execute stage
interface execute_md_if import riscv_pkg::*; #(parameter int XLEN = XLEN_DEFAULT);
  logic [XLEN-1:0] RD1_E, RD2_E, ImmExt_E, PC_E;
  logic [3:0]      ALUControl_E;
  logic            ALUSrc_E, Branch_E, Jump_E;
  logic            MDValid_E;
  logic [2:0]      MDOp_E;
  logic [XLEN-1:0] ALUResult_M, Result_W;
  logic [1:0]      ForwardA_E, ForwardB_E;
  logic [XLEN-1:0] ALUResult_E, WriteData_E, PCTarget_E;
  logic            PCSrc_E, Zero_E, MDBusy_E;
  modport master (
    output RD1_E, RD2_E, ImmExt_E, PC_E, ALUControl_E, ALUSrc_E, Branch_E, Jump_E,
           MDValid_E, MDOp_E, ALUResult_M, Result_W, ForwardA_E, ForwardB_E,
    input  ALUResult_E, WriteData_E, PCTarget_E, PCSrc_E, Zero_E, MDBusy_E
  );
  modport slave (
    input  RD1_E, RD2_E, ImmExt_E, PC_E, ALUControl_E, ALUSrc_E, Branch_E, Jump_E,
           MDValid_E, MDOp_E, ALUResult_M, Result_W, ForwardA_E, ForwardB_E,
    output ALUResult_E, WriteData_E, PCTarget_E, PCSrc_E, Zero_E, MDBusy_E
  );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 shift-add multiplier and restoring divider on magnitudes, sign fixed at the end
module muldiv_iter import riscv_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  md_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, opb_q, opb_d, res_q, res_d;
  logic negp_q, negp_d, negr_q, negr_d;
  logic a_sgn, b_sgn, div0, ovf, ge;
  logic [XLEN:0] sum, trial;
  logic [XLEN-1:0] acc_m, lo_m, acc_v, lo_v, diff, fin;
  logic [2*XLEN-1:0] prod;
  always_comb begin
    a_sgn = op != MD_MULHU && op != MD_DIVU && op != MD_REMU && a[XLEN-1];
    b_sgn = (op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_REM) && b[XLEN-1];
    div0 = op[2] && b == '0;
    ovf = (op == MD_DIV || op == MD_REM) && a == MIN && b == '1;
    sum = {1'b0, acc_q} + {1'b0, opb_q & {XLEN{lo_q[0]}}};
    acc_m = sum[XLEN:1];
    lo_m = {sum[0], lo_q[XLEN-1:1]};
    trial = {acc_q, lo_q[XLEN-1]};
    ge = trial >= {1'b0, opb_q};
    diff = trial[XLEN-1:0] - opb_q;
    acc_v = ge ? diff : trial[XLEN-1:0];
    lo_v = {lo_q[XLEN-2:0], ge};
    prod = negp_q ? -{acc_m, lo_m} : {acc_m, lo_m};
    fin = state_q == MD_MULS ? (op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
        : op_q[1] ? (negr_q ? -acc_v : acc_v) : (negp_q ? -lo_v : lo_v);
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    acc_d = acc_q;
    lo_d = lo_q;
    opb_d = opb_q;
    res_d = res_q;
    negp_d = negp_q;
    negr_d = negr_q;
    case (state_q)
      MD_IDLE: if (start) begin
        op_d = op;
        cnt_d = CW'(XLEN-1);
        acc_d = '0;
        lo_d = a_sgn ? -a : a;
        opb_d = b_sgn ? -b : b;
        negp_d = a_sgn ^ b_sgn;
        negr_d = a_sgn;
        state_d = (div0 || ovf) ? MD_DONE : op[2] ? MD_DIVS : MD_MULS;
        res_d = div0 ? (op[1] ? a : '1) : ovf ? (op[1] ? '0 : a) : res_q;
      end
      MD_MULS, MD_DIVS: begin
        acc_d = state_q == MD_MULS ? acc_m : acc_v;
        lo_d = state_q == MD_MULS ? lo_m : lo_v;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = MD_DONE;
          res_d = fin;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
      op_q <= '0;
      acc_q <= '0;
      lo_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      negp_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      acc_q <= acc_d;
      lo_q <= lo_d;
      opb_q <= opb_d;
      res_q <= res_d;
      negp_q <= negp_d;
      negr_q <= negr_d;
    end
  end
  assign busy = !rst && ((state_q == MD_IDLE && start) || state_q == MD_MULS || state_q == MD_DIVS);
  assign done = state_q == MD_DONE;
  assign result = res_q;
endmodule

// File: rtl/execute_md.sv
// execute_md: forwarding, Zba ALU, branch resolution and iterative M-extension unit for the EX stage
module execute_md import riscv_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) (
  input logic         clk,
  input logic         rst,
  execute_md_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, a_uw, md_res;
  logic [SW-1:0] sh;
  logic md_busy, md_done;
  alu_op_t alu_op;
  function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel, input logic [XLEN-1:0] rd, w, m);
    return sel == FWD_W ? w : sel == FWD_M ? m : rd;
  endfunction
  always_comb begin
    alu_op = alu_op_t'(bus.ALUControl_E);
    src_a = fwd(bus.ForwardA_E, bus.RD1_E, bus.Result_W, bus.ALUResult_M);
    fwd_b = fwd(bus.ForwardB_E, bus.RD2_E, bus.Result_W, bus.ALUResult_M);
    src_b = bus.ALUSrc_E ? bus.ImmExt_E : fwd_b;
    sh = src_b[SW-1:0];
    a_uw = '0;
    a_uw[31:0] = src_a[31:0];
    case (alu_op)
      ALU_ADD:    alu_res = src_a + src_b;
      ALU_SUB:    alu_res = src_a - src_b;
      ALU_AND:    alu_res = src_a & src_b;
      ALU_OR:     alu_res = src_a | src_b;
      ALU_XOR:    alu_res = src_a ^ src_b;
      ALU_SH1ADD: alu_res = src_b + (src_a << 1);
      ALU_SH2ADD: alu_res = src_b + (src_a << 2);
      ALU_SH3ADD: alu_res = src_b + (src_a << 3);
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:    alu_res = src_a << sh;
      ALU_SRL:    alu_res = src_a >> sh;
      ALU_SRA:    alu_res = $unsigned($signed(src_a) >>> sh);
      ALU_ADDUW:  alu_res = src_b + a_uw;
      ALU_PASSB:  alu_res = src_b;
      default:    alu_res = '0;
    endcase
  end
  muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (bus.MDValid_E),
    .op     (bus.MDOp_E),
    .a      (src_a),
    .b      (fwd_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );
  assign bus.ALUResult_E = md_done ? md_res : alu_res;
  assign bus.WriteData_E = fwd_b;
  assign bus.PCTarget_E = bus.PC_E + bus.ImmExt_E;
  assign bus.Zero_E = alu_res == '0;
  assign bus.PCSrc_E = (bus.Branch_E && bus.Zero_E) || bus.Jump_E;
  assign bus.MDBusy_E = md_busy;
endmodule
